// File: rtl/tda_pkg.sv
// Shared types and helpers for the persistence reduction engine.
//   state_t   : reduction controller states
//   pair_t    : (birth, death, dim) pair record at the default widths
//   betti_lsb : bit offset of Betti[d] inside the flattened Betti bus
package tda_pkg;

    localparam int DEF_MAX_COLS = 256;
    localparam int DEF_IDX_W    = $clog2(DEF_MAX_COLS);
    localparam int DEF_MAX_DIM  = 3;
    localparam int DEF_DIM_W    = 2;
    localparam int DEF_FILT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_LOW,
        ST_XOR,
        ST_EMIT,
        ST_BETTI,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] birth;
        logic [DEF_IDX_W-1:0] death;
        logic [DEF_DIM_W-1:0] dim;
    } pair_t;

    function automatic int betti_lsb(input int d, input int cnt_w);
        return d * cnt_w;
    endfunction

endpackage

// File: rtl/low_one_finder.sv
// Combinational priority encoder: index of the highest set bit of data.
//   data  : N-bit vector to search
//   found : at least one bit set
//   idx   : index of the highest set bit (0 when found=0)
module low_one_finder #(
    parameter int N     = 256,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     data,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // ascending scan, so the last hit (highest index) wins
        for (int i = 0; i < N; i++) begin
            if (data[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/persistence_reduce_engine.sv
// GF(2) lowest-one column reduction for persistent homology.
// Loads filtration-ordered boundary columns, reduces them with a
// pivot-owner table, streams (birth, death, dim) pairs and reports
// essential Betti counts per dimension.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start, abort               : session start / abort pulses
//   col_valid/ready/data/dim/filt/last : column input stream
//   pair_valid/ready/birth/death/dim   : pair output stream
//   betti_flat                 : Betti[d] at [d*CNT_W +: CNT_W]
//   num_pairs                  : pairs emitted this session
//   busy, done, err_overflow   : status
// Optional build macro ZERO_PERS_FILTER_EN: drop pairs whose birth and
// death filtration values are equal (bookkeeping unchanged).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting columns into column memory
// FETCH | read column j into working register
// LOW   | find lowest one (highest set bit) of working register
// XOR   | add owner column of current low into working register
// EMIT  | present pair (low, j)
// BETTI | count born-but-never-killed columns per dimension
// DONE  | results valid
module persistence_reduce_engine
    import tda_pkg::*;
#(
    parameter int MAX_COLS = DEF_MAX_COLS,
    parameter int IDX_W    = $clog2(MAX_COLS),
    parameter int MAX_DIM  = DEF_MAX_DIM,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int FILT_W   = DEF_FILT_W,
    parameter int CNT_W    = IDX_W + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         col_valid,
    output logic                         col_ready,
    input  logic [MAX_COLS-1:0]          col_data,
    input  logic [DIM_W-1:0]             col_dim,
    input  logic [FILT_W-1:0]            col_filt,
    input  logic                         col_last,
    output logic                         pair_valid,
    input  logic                         pair_ready,
    output logic [IDX_W-1:0]             pair_birth,
    output logic [IDX_W-1:0]             pair_death,
    output logic [DIM_W-1:0]             pair_dim,
    output logic [(MAX_DIM+1)*CNT_W-1:0] betti_flat,
    output logic [IDX_W:0]               num_pairs,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overflow
);

    localparam logic [IDX_W:0] N_FULL = (IDX_W+1)'(MAX_COLS);

    state_t state_q, state_d;

    logic [MAX_COLS-1:0] col_mem [MAX_COLS];
    logic [DIM_W-1:0]    dim_mem [MAX_COLS];
    logic [IDX_W-1:0]    owner   [MAX_COLS];
    logic [MAX_COLS-1:0] owner_valid_q, born_q, killed_q;
    logic [MAX_COLS-1:0] w_q;
    logic [IDX_W:0]      n_q, j_q, k_q;
    logic [IDX_W-1:0]    low_q;
    logic [CNT_W-1:0]    betti_q [MAX_DIM+1];

    logic             low_found;
    logic [IDX_W-1:0] low_idx;
    logic             emit_adv, last_col;
    logic [IDX_W-1:0] j_idx, k_idx;

    assign j_idx    = j_q[IDX_W-1:0];
    assign k_idx    = k_q[IDX_W-1:0];
    assign last_col = (j_q + 1'b1) == n_q;

    low_one_finder #(.N(MAX_COLS), .IDX_W(IDX_W)) u_low (
        .data  (w_q),
        .found (low_found),
        .idx   (low_idx)
    );

`ifdef ZERO_PERS_FILTER_EN
    logic [FILT_W-1:0] filt_mem [MAX_COLS];
    logic              zero_pers;
    assign zero_pers = filt_mem[low_q] == filt_mem[j_idx];
`else
    logic unused_filt;
    assign unused_filt = ^col_filt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        col_ready  = 1'b0;
        pair_valid = 1'b0;
        emit_adv   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (n_q == N_FULL) begin
                    state_d = ST_FETCH;
                end else begin
                    col_ready = 1'b1;
                    if (col_valid && col_last) state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOW;
            ST_LOW: begin
                if (!low_found)                  state_d = last_col ? ST_BETTI : ST_FETCH;
                else if (owner_valid_q[low_idx]) state_d = ST_XOR;
                else                             state_d = ST_EMIT;
            end
            ST_XOR: state_d = ST_LOW;
            ST_EMIT: begin
`ifdef ZERO_PERS_FILTER_EN
                if (zero_pers) begin
                    emit_adv = 1'b1;
                end else begin
                    pair_valid = 1'b1;
                    emit_adv   = pair_ready;
                end
`else
                pair_valid = 1'b1;
                emit_adv   = pair_ready;
`endif
                if (emit_adv) state_d = last_col ? ST_BETTI : ST_FETCH;
            end
            ST_BETTI: if ((k_q + 1'b1) == n_q) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = state_q == ST_DONE;
    assign pair_birth = pair_valid ? low_q : '0;
    assign pair_death = pair_valid ? j_idx : '0;
    assign pair_dim   = pair_valid ? dim_mem[low_q] : '0;

    // Memories carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (!abort) begin
            if (col_ready && col_valid) begin
                // faces must precede the simplex, so bits at or above n are dropped
                col_mem[n_q[IDX_W-1:0]] <= col_data & ~({MAX_COLS{1'b1}} << n_q);
                dim_mem[n_q[IDX_W-1:0]] <= col_dim;
`ifdef ZERO_PERS_FILTER_EN
                filt_mem[n_q[IDX_W-1:0]] <= col_filt;
`endif
            end
            if (state_q == ST_LOW && low_found && !owner_valid_q[low_idx]) begin
                owner[low_idx] <= j_idx;
                col_mem[j_idx] <= w_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            low_q         <= '0;
            w_q           <= '0;
            num_pairs     <= '0;
            err_overflow  <= 1'b0;
            owner_valid_q <= '0;
            born_q        <= '0;
            killed_q      <= '0;
            for (int d = 0; d <= MAX_DIM; d++) betti_q[d] <= '0;
        end else if (!abort) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        n_q           <= '0;
                        j_q           <= '0;
                        num_pairs     <= '0;
                        err_overflow  <= 1'b0;
                        owner_valid_q <= '0;
                        born_q        <= '0;
                        killed_q      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (n_q == N_FULL) begin
                        if (col_valid) err_overflow <= 1'b1;
                        j_q <= '0;
                    end else if (col_valid) begin
                        n_q <= n_q + 1'b1;
                        if (col_last) j_q <= '0;
                    end
                end
                ST_FETCH: w_q <= col_mem[j_idx];
                ST_LOW: begin
                    if (!low_found) begin
                        born_q[j_idx] <= 1'b1;
                        j_q           <= j_q + 1'b1;
                    end else begin
                        low_q <= low_idx;
                        if (!owner_valid_q[low_idx]) begin
                            owner_valid_q[low_idx] <= 1'b1;
                            killed_q[low_idx]      <= 1'b1;
                        end
                    end
                end
                ST_XOR: w_q <= w_q ^ col_mem[owner[low_q]];
                ST_EMIT: begin
                    if (emit_adv) begin
                        j_q <= j_q + 1'b1;
                        if (pair_valid) num_pairs <= num_pairs + 1'b1;
                    end
                end
                ST_BETTI: begin
                    for (int d = 0; d <= MAX_DIM; d++) begin
                        if (born_q[k_idx] && !killed_q[k_idx] && dim_mem[k_idx] == DIM_W'(d))
                            betti_q[d] <= betti_q[d] + 1'b1;
                    end
                    k_q <= k_q + 1'b1;
                end
                default: ;
            endcase
            if (state_d == ST_BETTI && state_q != ST_BETTI) begin
                k_q <= '0;
                for (int d = 0; d <= MAX_DIM; d++) betti_q[d] <= '0;
            end
        end
    end

    always_comb begin
        betti_flat = '0;
        for (int d = 0; d <= MAX_DIM; d++)
            betti_flat[betti_lsb(d, CNT_W) +: CNT_W] = betti_q[d];
    end

endmodule

// File: tb/tb_persistence_reduce_engine.sv
// Directed testbench for persistence_reduce_engine (default parameters).
// Builds with or without ZERO_PERS_FILTER_EN; expectations follow the macro.
module tb_persistence_reduce_engine;
    import tda_pkg::*;

    localparam int MAX_COLS = 256;
    localparam int IDX_W    = 8;
    localparam int MAX_DIM  = 3;
    localparam int DIM_W    = 2;
    localparam int FILT_W   = 16;
    localparam int CNT_W    = 9;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         start = 1'b0, abort = 1'b0;
    logic                         col_valid = 1'b0, col_last = 1'b0;
    logic                         col_ready;
    logic [MAX_COLS-1:0]          col_data = '0;
    logic [DIM_W-1:0]             col_dim = '0;
    logic [FILT_W-1:0]            col_filt = '0;
    logic                         pair_valid, pair_ready = 1'b1;
    logic [IDX_W-1:0]             pair_birth, pair_death;
    logic [DIM_W-1:0]             pair_dim;
    logic [(MAX_DIM+1)*CNT_W-1:0] betti_flat;
    logic [IDX_W:0]               num_pairs;
    logic                         busy, done, err_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [IDX_W-1:0] qb[$], qd[$];
    logic [DIM_W-1:0] qm[$];

    persistence_reduce_engine #(
        .MAX_COLS(MAX_COLS), .IDX_W(IDX_W), .MAX_DIM(MAX_DIM),
        .DIM_W(DIM_W), .FILT_W(FILT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
        .col_dim(col_dim), .col_filt(col_filt), .col_last(col_last),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_birth(pair_birth), .pair_death(pair_death), .pair_dim(pair_dim),
        .betti_flat(betti_flat), .num_pairs(num_pairs),
        .busy(busy), .done(done), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bt(input int b0, input int b1, input int b2, input int b3);
        return {28'd0, 9'(b3), 9'(b2), 9'(b1), 9'(b0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_col(input logic [MAX_COLS-1:0] data, input logic [DIM_W-1:0] dim,
                            input logic [FILT_W-1:0] filt, input logic last);
        bit ok;
        ok = 1'b0;
        col_data  = data;
        col_dim   = dim;
        col_filt  = filt;
        col_last  = last;
        col_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (col_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        col_valid = 1'b0;
        col_last  = 1'b0;
        chk("col_accept", 64'(ok), 64'd1);
    endtask

    // triangle complex: vertices 0..2, edges 3..5, optional face 6
    task automatic load_tri(input bit face, input bit same_filt);
        logic [MAX_COLS-1:0] d;
        logic [DIM_W-1:0]    m;
        for (int i = 0; i < 7; i++) begin
            if (i == 6 && !face) break;
            d = '0;
            m = '0;
            case (i)
                3: begin d[0] = 1'b1; d[1] = 1'b1; m = 2'd1; end
                4: begin d[1] = 1'b1; d[2] = 1'b1; m = 2'd1; end
                5: begin d[0] = 1'b1; d[2] = 1'b1; m = 2'd1; end
                6: begin d[3] = 1'b1; d[4] = 1'b1; d[5] = 1'b1; m = 2'd2; end
                default: ;
            endcase
            send_col(d, m, same_filt ? 16'd5 : 16'(10 + i), face ? (i == 6) : (i == 5));
        end
    endtask

    task automatic run_collect();
        qb.delete();
        qd.delete();
        qm.delete();
        for (int c = 0; c < 4000; c++) begin
            if (pair_valid && pair_ready) begin
                qb.push_back(pair_birth);
                qd.push_back(pair_death);
                qm.push_back(pair_dim);
            end
            tick();
            if (done) break;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic chk_pair(input int i, input int b, input int d, input int m);
        if (i < qb.size()) begin
            chk("pair_birth", 64'(qb[i]), 64'(b));
            chk("pair_death", 64'(qd[i]), 64'(d));
            chk("pair_dim",   64'(qm[i]), 64'(m));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_col_ready",  64'(col_ready), 64'd0);
        chk("rst_pair_valid", 64'(pair_valid), 64'd0);
        chk("rst_betti",      64'(betti_flat), 64'd0);
        chk("rst_num_pairs",  64'(num_pairs), 64'd0);
        chk("rst_busy",       64'(busy), 64'd0);
        chk("rst_done",       64'(done), 64'd0);
        chk("rst_err",        64'(err_overflow), 64'd0);

        // filled triangle with a 10-cycle stall on the first pair
        pair_ready = 1'b0;
        pulse_start();
        chk("load_busy", 64'(busy), 64'd1);
        load_tri(1'b1, 1'b0);
        for (int c = 0; c < 100; c++) begin
            if (pair_valid) break;
            tick();
        end
        chk("stall_first_valid", 64'(pair_valid), 64'd1);
        for (int s = 0; s < 10; s++) begin
            chk("stall_valid", 64'(pair_valid), 64'd1);
            chk("stall_birth", 64'(pair_birth), 64'd1);
            chk("stall_death", 64'(pair_death), 64'd3);
            chk("stall_dim",   64'(pair_dim),   64'd0);
            chk("stall_npairs", 64'(num_pairs), 64'd0);
            tick();
        end
        pair_ready = 1'b1;
        run_collect();
        chk("tri_pair_count", 64'(qb.size()), 64'd3);
        chk_pair(0, 1, 3, 0);
        chk_pair(1, 2, 4, 0);
        chk_pair(2, 5, 6, 1);
        chk("tri_num_pairs", 64'(num_pairs), 64'd3);
        chk("tri_betti", 64'(betti_flat), bt(1, 0, 0, 0));
        chk("tri_busy", 64'(busy), 64'd0);

        // hollow triangle: edge 5 reduces to zero and stays essential
        pulse_start();
        chk("hollow_done_clr", 64'(done), 64'd0);
        load_tri(1'b0, 1'b0);
        run_collect();
        chk("hollow_pair_count", 64'(qb.size()), 64'd2);
        chk_pair(0, 1, 3, 0);
        chk_pair(1, 2, 4, 0);
        chk("hollow_num_pairs", 64'(num_pairs), 64'd2);
        chk("hollow_betti", 64'(betti_flat), bt(1, 1, 0, 0));

        // abort while reducing edge 5 (first XOR step)
        pulse_start();
        load_tri(1'b1, 1'b0);
        for (int c = 0; c < 200; c++) begin
            if (dut.state_q == ST_XOR) break;
            tick();
        end
        chk("abort_reached_xor", 64'(dut.state_q == ST_XOR), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  64'(busy), 64'd0);
        chk("abort_pv",    64'(pair_valid), 64'd0);
        chk("abort_done",  64'(done), 64'd0);
        chk("abort_betti_hold", 64'(betti_flat), bt(1, 1, 0, 0));
        tick();
        chk("abort_idle_busy", 64'(busy), 64'd0);

        // four isolated vertices after abort
        pulse_start();
        for (int i = 0; i < 4; i++) send_col('0, 2'd0, 16'(i), i == 3);
        run_collect();
        chk("vert4_betti", 64'(betti_flat), bt(4, 0, 0, 0));
        chk("vert4_num_pairs", 64'(num_pairs), 64'd0);

        // overflow: 257 columns offered into 256 slots
        pulse_start();
        for (int i = 0; i < MAX_COLS; i++) send_col('0, 2'd0, 16'd0, 1'b0);
        chk("ovf_ready_low", 64'(col_ready), 64'd0);
        chk("ovf_err_before", 64'(err_overflow), 64'd0);
        col_valid = 1'b1;
        col_last  = 1'b1;
        tick();
        col_valid = 1'b0;
        col_last  = 1'b0;
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        run_collect();
        chk("ovf_betti", 64'(betti_flat), bt(256, 0, 0, 0));
        chk("ovf_err_sticky", 64'(err_overflow), 64'd1);
        chk("ovf_num_pairs", 64'(num_pairs), 64'd0);

        // triangle with equal filtration everywhere
        pulse_start();
        chk("err_cleared", 64'(err_overflow), 64'd0);
        load_tri(1'b1, 1'b1);
        run_collect();
`ifdef ZERO_PERS_FILTER_EN
        chk("zp_pair_count", 64'(qb.size()), 64'd0);
        chk("zp_num_pairs", 64'(num_pairs), 64'd0);
`else
        chk("eqf_pair_count", 64'(qb.size()), 64'd3);
        chk_pair(2, 5, 6, 1);
        chk("eqf_num_pairs", 64'(num_pairs), 64'd3);
`endif
        chk("eqf_betti", 64'(betti_flat), bt(1, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/persistence_reduce_engine.md
Name: persistence_reduce_engine

Overview:
Next-generation GF(2) persistent-homology reduction engine for the TDA accelerator path. It accepts filtration-ordered boundary columns over a valid/ready stream and stores them in on-chip column memory. It runs standard lowest-one column reduction with a pivot-owner table, streams (birth, death, dim) pairs out, and reports essential Betti counts per dimension. It is parametrised in depth and dimension count and adds backpressure, abort and error reporting.

Parameters:
MAX_COLS, 256, maximum simplices (columns); also the column bit width
IDX_W, $clog2(MAX_COLS), column index width
MAX_DIM, 3, highest homology dimension tracked (Betti[0..MAX_DIM])
DIM_W, 2, simplex dimension field width; must satisfy 2**DIM_W > MAX_DIM
FILT_W, 16, filtration value width
CNT_W, IDX_W+1, Betti counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a load session (ignored unless IDLE or DONE)
abort  in  1  pulse; returns to IDLE from any state next cycle
col_valid  in  1  column beat valid
col_ready  out  1  engine accepts column
col_data  in  MAX_COLS  boundary column; bit i set = face i
col_dim  in  DIM_W  simplex dimension of the column
col_filt  in  FILT_W  filtration value of the column
col_last  in  1  final column of the complex
pair_valid  out  1  pair beat valid
pair_ready  in  1  downstream accepts pair
pair_birth  out  IDX_W  birth column index
pair_death  out  IDX_W  death column index
pair_dim  out  DIM_W  dimension of the killed class (= col_dim of the birth column)
betti_flat  out  (MAX_DIM+1)*CNT_W  Betti[d] at bits [d*CNT_W +: CNT_W]
num_pairs  out  IDX_W+1  pairs emitted this session
busy  out  1  high outside IDLE/DONE
done  out  1  high in DONE
err_overflow  out  1  sticky: column offered after MAX_COLS accepted

Behaviour:
- Reset: all outputs 0; FSM=IDLE; pivot-owner valid bits cleared; column memory contents undefined.
- FSM states: IDLE, LOAD, FETCH, LOW, XOR, EMIT, BETTI, DONE.
- IDLE/DONE + start -> LOAD. Clears n, num_pairs, err_overflow, all owner-valid, born and killed flags. Betti outputs hold their old values until BETTI rewrites them.
- LOAD: col_ready=1 while n<MAX_COLS. A handshake writes column n with bits [MAX_COLS-1:n] masked to 0, stores dim and filt, then n++. col_last on an accepted beat -> FETCH with j=0.
- LOAD at n==MAX_COLS: col_ready=0. A col_valid in this state sets err_overflow. The engine then proceeds to FETCH with n=MAX_COLS.
- FETCH (1 cycle): read column j into working register W -> LOW.
- LOW (1 cycle): compute low = highest set bit of W.
  - W==0: set born[j]; j++ -> FETCH, or BETTI if j==n.
  - owner_valid[low]: -> XOR.
  - otherwise: owner[low]=j, owner_valid[low]=1, killed[low]=1, write W back to column j -> EMIT.
- XOR (1 cycle): W ^= column[owner[low]] -> LOW. Worst-case cost per column is 2 cycles per XOR step.
- EMIT: pair_valid=1 with birth=low, death=j, dim=dim[low]. Outputs are stable until pair_ready. On handshake num_pairs++, j++ -> FETCH, or BETTI if j==n.
- BETTI: scan k=0..n-1, one per cycle. If born[k] && !killed[k] && dim[k]<=MAX_DIM, Betti[dim[k]]++. Counters are zeroed on entry. Then -> DONE.
- DONE: done=1 until start or abort.
- abort wins over every other event in the same cycle. An in-flight pair is dropped: pair_valid drops the next cycle.
- start while busy is ignored.
- Reset mid-operation behaves as full reset.

Optional Feature:
ZERO_PERS_FILTER_EN. When defined, EMIT suppresses pairs with filt[low]==filt[j]: no pair_valid, num_pairs is not incremented, and the FSM advances directly. Owner and killed bookkeeping is unchanged, so Betti is identical. When undefined, every pair is emitted.

Decomposition:
- Package tda_pkg: FSM state enum; the pair struct {birth, death, dim}; a Betti-index helper function; default-width localparams.
- One sub-module, low_one_finder: combinational priority encoder over MAX_COLS giving {found, idx} for the highest set bit. It is reused by the FSM in the LOW state.

Test Plan:
- Triangle boundary: 3 vertices (dim0, zero columns), 3 edges (cols 3..5: {0,1},{1,2},{0,2}), 1 face (col6: {3,4,5}) -> pairs (1,3,0),(2,4,0),(5,6,1); Betti={1,0,0,0}; num_pairs=3.
- Hollow triangle (no face) -> pairs (1,3),(2,4); edge 5 reduces to zero; Betti={1,1,0,0}.
- Hold pair_ready=0 for 10 cycles on the first pair -> pair fields stable, no FSM advance, no lost or duplicated pairs.
- Stream 257 columns with MAX_COLS=256 -> col_ready low after 256; err_overflow=1; done still reached.
- abort asserted during XOR -> next cycle busy=0, pair_valid=0. A new start with a 4-vertex set gives Betti={4,0,0,0}.
- With ZERO_PERS_FILTER_EN defined, triangle with all filt=5 -> zero pairs emitted, num_pairs=0, Betti={1,0,0,0}.
